// File: rtl/m_imem_loader_pkg.sv
// m_imem_loader_pkg: shared frame constants and loader state encoding
package m_imem_loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/m_imem_loader_word_pack.sv
// m_word_pack: shifts bytes MSB-first into 32-bit words, keeps the running checksum, flags the 4th byte
module m_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [7:0]  csum,
    output logic        ready
);
    logic [23:0] sh;
    logic [1:0]  cnt;
    assign word  = {sh, data};
    assign ready = en && cnt == 2'd3;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sh   <= '0;
            cnt  <= '0;
            csum <= '0;
        end else if (en) begin
            sh   <= word[23:0];
            cnt  <= cnt + 2'd1;
            csum <= csum + data;
        end
    end
endmodule

// File: rtl/m_imem_loader.sv
// m_imem_loader: byte-stream framed loader writing 32-bit words to instruction memory, holding the cpu in reset until a good frame
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter int          DEPTH   = 4096,
    parameter int          TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = SYNC_BYTE
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_bvalid,
    input  logic [7:0]        w_bdata,
    output logic              r_bready,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_we,
    output logic [31:0]       r_din,
    output logic              r_cpu_rst,
    output logic              r_done,
    output logic              r_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    state_t      state, nxt;
    logic        acc, start, busy, timeout, ready;
    logic [7:0]  cnt_hi, csum;
    logic [15:0] n, n_full, widx;
    logic [31:0] word;
    logic [TW-1:0] idle;
    assign acc     = w_bvalid & r_bready;
    assign start   = acc && w_bdata == SYNC && (state == IDLE || state == DONE || state == ERR);
    assign busy    = state == CNT_HI || state == CNT_LO || state == DATA || state == CSUM;
    assign timeout = busy && !acc && idle == TW'(TIMEOUT - 1);
    assign n_full  = {cnt_hi, w_bdata};
    m_word_pack u_pack (
        .clk   (w_clk),
        .rst   (w_rst),
        .clr   (start),
        .en    (acc && state == DATA),
        .data  (w_bdata),
        .word  (word),
        .csum  (csum),
        .ready (ready)
    );
    always_ff @(posedge w_clk) begin
        if (w_rst) state <= IDLE;
        else       state <= nxt;
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE, ERR: nxt = start ? CNT_HI : state;
            CNT_HI:          nxt = acc ? CNT_LO : state;
            CNT_LO:          nxt = !acc ? state : {1'b0, n_full} > DEPTH_W ? ERR : n_full == 16'd0 ? CSUM : DATA;
            DATA:            nxt = ready && widx + 16'd1 == n ? CSUM : state;
            CSUM:            nxt = !acc ? state : w_bdata == csum ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
        if (timeout) nxt = ERR;
    end
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_bready  <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_din     <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            cnt_hi    <= '0;
            n         <= '0;
            widx      <= '0;
            idle      <= '0;
        end else begin
            r_bready <= 1'b1;
            r_we     <= ready;
            idle     <= busy && !acc && !timeout ? idle + 1'b1 : '0;
            if (ready) begin
                r_din  <= word;
                r_addr <= widx[ADDR_W-1:0];
                widx   <= widx + 16'd1;
            end
            if (state == CNT_HI && acc) cnt_hi <= w_bdata;
            if (state == CNT_LO && acc) n <= n_full;
            if (start) begin
                widx      <= '0;
                r_cpu_rst <= 1'b1;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
            end
            if (state != DONE && nxt == DONE) begin
                r_done    <= 1'b1;
                r_cpu_rst <= 1'b0;
            end
            if (state != ERR && nxt == ERR) r_err <= 1'b1;
        end
    end
endmodule
